// File: rtl/op_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// op_scheduler_pkg
// Purpose : Shared definitions for the FHE op scheduler slice. Holds the
//           controller opcode encodings and a helper that sizes one queued
//           command word.
// Contents: opcode_t, OPCODE_* constants, cmd_width()
// ---------------------------------------------------------------------------
package op_scheduler_pkg;

  typedef logic [1:0] opcode_t;

  // Opcode encodings shared with the FHE op controller.
  localparam opcode_t OPCODE_ENCRYPT = 2'd0;
  localparam opcode_t OPCODE_DECRYPT = 2'd1;
  localparam opcode_t OPCODE_ADD     = 2'd2;
  localparam opcode_t OPCODE_MULT    = 2'd3;

  // Width of one packed command: opcode, three base addresses, noise, tag.
  function automatic int cmd_width(input int addr_w, input int noise_w, input int tag_w);
    return 2 + 3 * addr_w + noise_w + tag_w;
  endfunction

endpackage

// File: rtl/op_scheduler_if.sv
// ---------------------------------------------------------------------------
// op_scheduler_if
// Purpose : Bundles the three scheduler buses: host command push, controller
//           config/done, and host completion response, plus status.
// Modports:
//   slave  - the scheduler (consumes commands, drives controller + response)
//   master - the environment (host glue and controller)
// Signals : cmd_valid/ready/opcode/op1_addr/op2_addr/out_addr/noise/tag,
//           ctrl_config_en/opcode/op1_base_addr/op2_base_addr/out_base_addr/
//           noise/done, rsp_valid/ready/tag/timeout, busy, queue_count
// ---------------------------------------------------------------------------
interface op_scheduler_if
  import op_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int BIG_N          = 30,
  parameter int TAG_WIDTH      = 4,
  parameter int FIFO_PTR_WIDTH = 2
) ();

  logic                    cmd_valid;
  logic                    cmd_ready;
  opcode_t                 cmd_opcode;
  logic [ADDR_WIDTH-1:0]   cmd_op1_addr;
  logic [ADDR_WIDTH-1:0]   cmd_op2_addr;
  logic [ADDR_WIDTH-1:0]   cmd_out_addr;
  logic [BIG_N-1:0]        cmd_noise;
  logic [TAG_WIDTH-1:0]    cmd_tag;

  logic                    ctrl_config_en;
  opcode_t                 ctrl_opcode;
  logic [ADDR_WIDTH-1:0]   ctrl_op1_base_addr;
  logic [ADDR_WIDTH-1:0]   ctrl_op2_base_addr;
  logic [ADDR_WIDTH-1:0]   ctrl_out_base_addr;
  logic [BIG_N-1:0]        ctrl_noise;
  logic                    ctrl_done;

  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [TAG_WIDTH-1:0]    rsp_tag;
  logic                    rsp_timeout;

  logic                    busy;
  logic [FIFO_PTR_WIDTH:0] queue_count;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_op1_addr, cmd_op2_addr, cmd_out_addr, cmd_noise, cmd_tag,
    output cmd_ready,
    output ctrl_config_en, ctrl_opcode, ctrl_op1_base_addr, ctrl_op2_base_addr,
           ctrl_out_base_addr, ctrl_noise,
    input  ctrl_done,
    output rsp_valid, rsp_tag, rsp_timeout,
    input  rsp_ready,
    output busy, queue_count
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_op1_addr, cmd_op2_addr, cmd_out_addr, cmd_noise, cmd_tag,
    input  cmd_ready,
    input  ctrl_config_en, ctrl_opcode, ctrl_op1_base_addr, ctrl_op2_base_addr,
           ctrl_out_base_addr, ctrl_noise,
    output ctrl_done,
    input  rsp_valid, rsp_tag, rsp_timeout,
    output rsp_ready,
    input  busy, queue_count
  );

endinterface

// File: rtl/op_scheduler_cmd_fifo.sv
// ---------------------------------------------------------------------------
// cmd_fifo
// Purpose : Synchronous command queue for the op scheduler. Head entry is
//           visible on rdata_o whenever the queue is non-empty.
// Ports   : clk, rst_n (async active-low)
//           push_i/wdata_i - write request (ignored when full)
//           pop_i          - remove head (ignored when empty)
//           rdata_o        - head entry
//           full_o/empty_o/count_o - occupancy status
// ---------------------------------------------------------------------------
module cmd_fifo #(
  parameter int WIDTH     = 66,
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [WIDTH-1:0]     wdata_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic [PTR_WIDTH:0]   count_o
);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q;
  logic [PTR_WIDTH-1:0] rd_ptr_q;
  logic [PTR_WIDTH:0]   count_q;
  logic                 do_push;
  logic                 do_pop;

  // Full blocks a push even when a pop happens in the same cycle.
  assign full_o  = (count_q == (PTR_WIDTH+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_WIDTH+1)'(1);
        2'b01:   count_q <= count_q - (PTR_WIDTH+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy tracking alone decides validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/op_scheduler.sv
// ---------------------------------------------------------------------------
// op_scheduler
// Purpose : Command front-end for the FHE op controller. Queues host commands,
//           issues them one at a time through the controller config strobe,
//           waits for done (or a watchdog timeout) and returns the tag.
// Ports   : clk, rst_n (async active-low)
//           bus (op_scheduler_if.slave) - command, controller and response
//           buses plus busy/queue_count status
// ---------------------------------------------------------------------------
module op_scheduler
  import op_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH     = 10,
  parameter int BIG_N          = 30,
  parameter int TAG_WIDTH      = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int FIFO_PTR_WIDTH = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  op_scheduler_if.slave bus
);

  localparam int CMD_WIDTH = cmd_width(ADDR_WIDTH, BIG_N, TAG_WIDTH);
  localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CONFIG = 3'd1;
  localparam logic [2:0] ST_ARM    = 3'd2;
  localparam logic [2:0] ST_RUN    = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  logic [CMD_WIDTH-1:0]      fifo_rdata;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [FIFO_PTR_WIDTH:0]   fifo_count;
  logic                      pop;

  opcode_t                   head_opcode;
  logic [ADDR_WIDTH-1:0]     head_op1;
  logic [ADDR_WIDTH-1:0]     head_op2;
  logic [ADDR_WIDTH-1:0]     head_out;
  logic [BIG_N-1:0]          head_noise;
  logic [TAG_WIDTH-1:0]      head_tag;

  logic [2:0]                state_q,       state_d;
  logic [CNT_WIDTH-1:0]      cnt_q,         cnt_d;
  logic                      cfg_en_q,      cfg_en_d;
  opcode_t                   opcode_q,      opcode_d;
  logic [ADDR_WIDTH-1:0]     op1_q,         op1_d;
  logic [ADDR_WIDTH-1:0]     op2_q,         op2_d;
  logic [ADDR_WIDTH-1:0]     out_q,         out_d;
  logic [BIG_N-1:0]          noise_q,       noise_d;
  logic [TAG_WIDTH-1:0]      tag_q,         tag_d;
  logic                      rsp_valid_q,   rsp_valid_d;
  logic [TAG_WIDTH-1:0]      rsp_tag_q,     rsp_tag_d;
  logic                      rsp_timeout_q, rsp_timeout_d;

  cmd_fifo #(
    .WIDTH     (CMD_WIDTH),
    .DEPTH     (FIFO_DEPTH),
    .PTR_WIDTH (FIFO_PTR_WIDTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (bus.cmd_valid),
    .pop_i   (pop),
    .wdata_i ({bus.cmd_opcode, bus.cmd_op1_addr, bus.cmd_op2_addr, bus.cmd_out_addr,
               bus.cmd_noise, bus.cmd_tag}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign {head_opcode, head_op1, head_op2, head_out, head_noise, head_tag} = fifo_rdata;

  assign bus.cmd_ready          = !fifo_full;
  assign bus.queue_count        = fifo_count;
  assign bus.busy               = (state_q != ST_IDLE) || !fifo_empty;
  assign bus.ctrl_config_en     = cfg_en_q;
  assign bus.ctrl_opcode        = opcode_q;
  assign bus.ctrl_op1_base_addr = op1_q;
  assign bus.ctrl_op2_base_addr = op2_q;
  assign bus.ctrl_out_base_addr = out_q;
  assign bus.ctrl_noise         = noise_q;
  assign bus.rsp_valid          = rsp_valid_q;
  assign bus.rsp_tag            = rsp_tag_q;
  assign bus.rsp_timeout        = rsp_timeout_q;

  // Next-state logic. The ARM state exists so that a done left over from the
  // previous op is never mistaken for completion: the controller only clears
  // done once it has sampled the config strobe.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cfg_en_d      = 1'b0;
    opcode_d      = opcode_q;
    op1_d         = op1_q;
    op2_d         = op2_q;
    out_d         = out_q;
    noise_d       = noise_q;
    tag_d         = tag_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_timeout_d = rsp_timeout_q;
    pop           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          opcode_d = head_opcode;
          op1_d    = head_op1;
          op2_d    = head_op2;
          out_d    = head_out;
          noise_d  = head_noise;
          tag_d    = head_tag;
          state_d  = ST_CONFIG;
        end
      end
      ST_CONFIG: begin
        cfg_en_d = 1'b1;
        state_d  = ST_ARM;
      end
      ST_ARM: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // A real done beats a watchdog expiry in the same cycle.
        if (bus.ctrl_done) begin
          rsp_valid_d   = 1'b1;
          rsp_tag_d     = tag_q;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_valid_d   = 1'b1;
          rsp_tag_d     = tag_q;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All scheduler outputs are registered; reset drops any in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      cfg_en_q      <= 1'b0;
      opcode_q      <= OPCODE_ENCRYPT;
      op1_q         <= '0;
      op2_q         <= '0;
      out_q         <= '0;
      noise_q       <= '0;
      tag_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_tag_q     <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cfg_en_q      <= cfg_en_d;
      opcode_q      <= opcode_d;
      op1_q         <= op1_d;
      op2_q         <= op2_d;
      out_q         <= out_d;
      noise_q       <= noise_d;
      tag_q         <= tag_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_op_scheduler.sv
// ---------------------------------------------------------------------------
// tb_op_scheduler
// Purpose : Directed self-checking bench for op_scheduler with a short
//           watchdog (16 cycles). Drives the host and controller sides of the
//           interface and logs config strobes and response handshakes.
// ---------------------------------------------------------------------------
module tb_op_scheduler;
  import op_scheduler_pkg::*;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  int         cfgCount = 0;
  logic [9:0] cfgAddr[$];
  logic [3:0] rspTags[$];
  logic       rspTimeouts[$];

  op_scheduler_if #(
    .ADDR_WIDTH(10), .BIG_N(30), .TAG_WIDTH(4), .FIFO_PTR_WIDTH(2)
  ) bus ();

  op_scheduler #(
    .ADDR_WIDTH(10), .BIG_N(30), .TAG_WIDTH(4), .FIFO_DEPTH(4),
    .FIFO_PTR_WIDTH(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every config strobe and every completed response handshake.
  always @(posedge clk) begin
    if (rst_n && bus.ctrl_config_en) begin
      cfgCount++;
      cfgAddr.push_back(bus.ctrl_op1_base_addr);
    end
    if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
      rspTags.push_back(bus.rsp_tag);
      rspTimeouts.push_back(bus.rsp_timeout);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present one command for one clock edge; returns cmd_ready as seen before the edge.
  task automatic applyStimulus(input opcode_t op, input logic [9:0] a1, input logic [9:0] a2,
                               input logic [9:0] ao, input logic [29:0] noise,
                               input logic [3:0] tag, output logic readySeen);
    bus.cmd_valid    = 1'b1;
    bus.cmd_opcode   = op;
    bus.cmd_op1_addr = a1;
    bus.cmd_op2_addr = a2;
    bus.cmd_out_addr = ao;
    bus.cmd_noise    = noise;
    bus.cmd_tag      = tag;
    readySeen        = bus.cmd_ready;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid    = 1'b0;
  endtask

  task automatic waitCfg(input int maxCycles);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ctrl_config_en && n < maxCycles);
    checkOutput("cfgWait", 64'(bus.ctrl_config_en), 64'd1);
  endtask

  initial begin
    logic       rdy;
    logic [4:0] readyLog;
    int         n;

    rst_n            = 1'b0;
    bus.cmd_valid    = 1'b0;
    bus.cmd_opcode   = OPCODE_ENCRYPT;
    bus.cmd_op1_addr = '0;
    bus.cmd_op2_addr = '0;
    bus.cmd_out_addr = '0;
    bus.cmd_noise    = '0;
    bus.cmd_tag      = '0;
    bus.ctrl_done    = 1'b0;
    bus.rsp_ready    = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rstCmdReady", 64'(bus.cmd_ready),      64'd1);
    checkOutput("rstCfgEn",    64'(bus.ctrl_config_en), 64'd0);
    checkOutput("rstRspValid", 64'(bus.rsp_valid),      64'd0);
    checkOutput("rstBusy",     64'(bus.busy),           64'd0);
    checkOutput("rstCount",    64'(bus.queue_count),    64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single ADD op");
    applyStimulus(OPCODE_ADD, 10'h010, 10'h020, 10'h030, 30'h0, 4'd5, rdy);
    checkOutput("t1Accept", 64'(rdy),             64'd1);
    checkOutput("t1Count",  64'(bus.queue_count), 64'd1);
    checkOutput("t1Busy",   64'(bus.busy),        64'd1);
    @(negedge clk);
    checkOutput("t1NoEarlyCfg", 64'(bus.ctrl_config_en), 64'd0);
    @(negedge clk);
    checkOutput("t1CfgEn",  64'(bus.ctrl_config_en),     64'd1);
    checkOutput("t1Opcode", 64'(bus.ctrl_opcode),        64'd2);
    checkOutput("t1Op1",    64'(bus.ctrl_op1_base_addr), 64'h010);
    checkOutput("t1Op2",    64'(bus.ctrl_op2_base_addr), 64'h020);
    checkOutput("t1Out",    64'(bus.ctrl_out_base_addr), 64'h030);
    repeat (10) @(negedge clk);
    checkOutput("t1NoEarlyRsp", 64'(bus.rsp_valid), 64'd0);
    bus.ctrl_done = 1'b1;
    @(negedge clk);
    checkOutput("t1RspValid",   64'(bus.rsp_valid),   64'd1);
    checkOutput("t1RspTag",     64'(bus.rsp_tag),     64'd5);
    checkOutput("t1RspTimeout", 64'(bus.rsp_timeout), 64'd0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("t1RspDrop", 64'(bus.rsp_valid), 64'd0);
    checkOutput("t1Idle",    64'(bus.busy),      64'd0);
    checkOutput("t1CfgOnce", 64'(cfgCount),      64'd1);

    $display("[TB] stale done held high, blocker op held in response");
    bus.rsp_ready = 1'b0;
    applyStimulus(OPCODE_MULT, 10'h3FF, 10'h3FE, 10'h3FD, 30'h3FFFFFFF, 4'd9, rdy);
    @(negedge clk);
    checkOutput("t3CfgStageNoRsp", 64'(bus.rsp_valid), 64'd0);
    @(negedge clk);
    checkOutput("t3ArmCfgEn",  64'(bus.ctrl_config_en), 64'd1);
    checkOutput("t3ArmNoRsp",  64'(bus.rsp_valid),      64'd0);
    @(negedge clk);
    checkOutput("t3RunNoRsp",  64'(bus.rsp_valid),      64'd0);
    checkOutput("t3RunCfgLow", 64'(bus.ctrl_config_en), 64'd0);
    @(negedge clk);
    checkOutput("t3RspValid", 64'(bus.rsp_valid), 64'd1);
    checkOutput("t3RspTag",   64'(bus.rsp_tag),   64'd9);

    $display("[TB] fill queue while response is stalled");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(opcode_t'(i % 4), 10'(i), 10'(i + 16), 10'(i + 32), 30'(i), 4'(i), rdy);
      readyLog[i] = rdy;
      checkOutput("t5HoldValid", 64'(bus.rsp_valid), 64'd1);
      checkOutput("t5HoldTag",   64'(bus.rsp_tag),   64'd9);
    end
    checkOutput("t2ReadyLog", 64'(readyLog),        64'b01111);
    checkOutput("t2Count",    64'(bus.queue_count), 64'd4);
    checkOutput("t2Full",     64'(bus.cmd_ready),   64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("t5HoldValid", 64'(bus.rsp_valid),      64'd1);
      checkOutput("t5HoldTag",   64'(bus.rsp_tag),        64'd9);
      checkOutput("t5NoCfg",     64'(bus.ctrl_config_en), 64'd0);
    end
    checkOutput("t5CfgCount", 64'(cfgCount), 64'd2);

    $display("[TB] drain queue with done held high");
    bus.rsp_ready = 1'b1;
    n = 0;
    while (rspTags.size() < 6 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t2RspCount", 64'(rspTags.size()), 64'd6);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t2OrderTag",  64'(rspTags[i + 2]),     64'(i));
      checkOutput("t2OrderAddr", 64'(cfgAddr[i + 2]),     64'(i));
      checkOutput("t3NoTimeout", 64'(rspTimeouts[i + 2]), 64'd0);
    end
    checkOutput("t3CfgCount",  64'(cfgCount),               64'd6);
    checkOutput("holdOpcode",  64'(bus.ctrl_opcode),        64'd3);
    checkOutput("holdOp1",     64'(bus.ctrl_op1_base_addr), 64'd3);
    checkOutput("holdOut",     64'(bus.ctrl_out_base_addr), 64'd35);
    checkOutput("t2Idle",      64'(bus.busy),               64'd0);

    $display("[TB] watchdog timeout");
    bus.ctrl_done = 1'b0;
    applyStimulus(OPCODE_ENCRYPT, 10'h100, 10'h101, 10'h102, 30'h2AAAAAAA, 4'd7, rdy);
    applyStimulus(OPCODE_DECRYPT, 10'h200, 10'h201, 10'h202, 30'h15555555, 4'd8, rdy);
    waitCfg(10);
    checkOutput("t4Noise", 64'(bus.ctrl_noise),         64'h2AAAAAAA);
    checkOutput("t4Op1",   64'(bus.ctrl_op1_base_addr), 64'h100);
    n = 0;
    while (!bus.rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t4Latency", 64'(n),               64'd17);
    checkOutput("t4Timeout", 64'(bus.rsp_timeout), 64'd1);
    checkOutput("t4Tag",     64'(bus.rsp_tag),     64'd7);
    waitCfg(10);
    checkOutput("t4NextOp1",    64'(bus.ctrl_op1_base_addr), 64'h200);
    checkOutput("t4NextOpcode", 64'(bus.ctrl_opcode),        64'd1);

    $display("[TB] reset during RUN with queued commands");
    @(negedge clk);
    applyStimulus(OPCODE_ADD,  10'h050, 10'h051, 10'h052, 30'h1, 4'd10, rdy);
    applyStimulus(OPCODE_MULT, 10'h060, 10'h061, 10'h062, 30'h2, 4'd11, rdy);
    checkOutput("t6Count",    64'(bus.queue_count),    64'd2);
    checkOutput("t6Busy",     64'(bus.busy),           64'd1);
    checkOutput("t6Running",  64'(bus.rsp_valid),      64'd0);
    checkOutput("t6RspLog",   64'(rspTags.size()),     64'd7);
    checkOutput("t6LastTag",  64'(rspTags[6]),         64'd7);
    checkOutput("t6LastTo",   64'(rspTimeouts[6]),     64'd1);
    checkOutput("t6CfgCount", 64'(cfgCount),           64'd8);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t6AsyncCount",  64'(bus.queue_count),        64'd0);
    checkOutput("t6AsyncBusy",   64'(bus.busy),               64'd0);
    checkOutput("t6AsyncCfg",    64'(bus.ctrl_config_en),     64'd0);
    checkOutput("t6AsyncRsp",    64'(bus.rsp_valid),          64'd0);
    checkOutput("t6AsyncTag",    64'(bus.rsp_tag),            64'd0);
    checkOutput("t6AsyncOpcode", 64'(bus.ctrl_opcode),        64'd0);
    checkOutput("t6AsyncOp1",    64'(bus.ctrl_op1_base_addr), 64'd0);
    checkOutput("t6AsyncNoise",  64'(bus.ctrl_noise),         64'd0);
    checkOutput("t6AsyncReady",  64'(bus.cmd_ready),          64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("t6NoRsp",  64'(rspTags.size()),  64'd7);
    checkOutput("t6NoCfg",  64'(cfgCount),        64'd8);
    checkOutput("t6Idle",   64'(bus.busy),        64'd0);
    checkOutput("t6Empty",  64'(bus.queue_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
